// File: rtl/retire_checker_pkg.sv
// Shared types and constants for the in-order retirement checker.
// Expected-entry layout, checker states and RV32 opcode values.
package retire_checker_pkg;

    localparam int XLEN_DEF = 32;

    typedef struct packed {
        logic [31:0]         instr;
        logic                we;
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] data;
    } exp_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } chk_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

endpackage

// File: rtl/retire_checker_if.sv
// Expectation push port and CPU retire port of the retirement checker.
// master = golden model + CPU side, slave = checker.
interface retire_checker_if #(
    parameter int XLEN = 32
);
    logic            exp_valid;
    logic [31:0]     exp_instr;
    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    logic            exp_ready;

    logic            ret_valid;
    logic [31:0]     ret_instr;
    logic            ret_we;
    logic [4:0]      ret_rd;
    logic [XLEN-1:0] ret_data;

    modport master (
        output exp_valid, exp_instr, exp_we, exp_rd, exp_data,
        output ret_valid, ret_instr, ret_we, ret_rd, ret_data,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_instr, exp_we, exp_rd, exp_data,
        input  ret_valid, ret_instr, ret_we, ret_rd, ret_data,
        output exp_ready
    );
endinterface

// File: rtl/retire_checker_chk_fifo.sv
// Synchronous FIFO with combinational head; push/pop gating is done by the caller.
// Pointers carry one extra wrap bit so full/empty need no separate count.
module chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Push-while-full is only issued with a same-cycle pop, so the slot being
    // overwritten is the head that is leaving.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/retire_checker.sv
// In-order retirement checker: FIFO of expected results popped by CPU retirements.
// Holds the run/drain/done/err FSM, comparator, saturating counters and watchdog.
module retire_checker
    import retire_checker_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_on_fail,
    input  logic             end_test,
    retire_checker_if.slave  bus,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             mismatch,
    output logic [31:0]      fail_instr,
    output logic [XLEN-1:0]  fail_data,
    output logic             overflow,
    output logic             timeout,
    output logic             done,
    output logic             halt
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    chk_state_e      state_q, state_d;
    exp_entry_t      wr_entry, head;
    logic            full, empty;
    logic            active, push_req, push, pop;
    logic            underflow, ovf_evt, match, pass_evt, fail_evt, wd_hit;
    logic [WD_W-1:0] wd_q;

    assign wr_entry = '{instr: bus.exp_instr, we: bus.exp_we, rd: bus.exp_rd, data: bus.exp_data};

    chk_fifo #(
        .WIDTH ($bits(exp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        active    = (state_q == RUN) || (state_q == DRAIN);
        push_req  = bus.exp_valid && (state_q == RUN);
        pop       = bus.ret_valid && active && !empty;
        underflow = bus.ret_valid && active && empty;
        // A full FIFO still accepts a push when the head leaves this cycle.
        push      = push_req && (!full || pop);
        ovf_evt   = push_req && full && !pop;
        match     = (head.instr == bus.ret_instr) && (head.we == bus.ret_we) &&
                    (!head.we || ((head.rd == bus.ret_rd) &&
                                  ((head.rd == 5'd0) || (head.data == bus.ret_data))));
        pass_evt  = pop && match;
        fail_evt  = underflow || (pop && !match);
        wd_hit    = active && !empty && !bus.ret_valid && (wd_q == WD_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (end_test) state_d = DRAIN;
            DRAIN:   if (empty && !bus.ret_valid) state_d = DONE;
            default: state_d = state_q;
        endcase
        if (active && (ovf_evt || wd_hit || (fail_evt && stop_on_fail))) state_d = ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            mismatch   <= 1'b0;
            fail_instr <= '0;
            fail_data  <= '0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            wd_q       <= '0;
        end else begin
            mismatch <= fail_evt;
            if (pass_evt && (pass_cnt != '1)) pass_cnt <= pass_cnt + 1'b1;
            if (fail_evt && (fail_cnt != '1)) fail_cnt <= fail_cnt + 1'b1;
            if (fail_evt && (fail_cnt == '0)) begin
                fail_instr <= bus.ret_instr;
                fail_data  <= bus.ret_data;
            end
            if (ovf_evt) overflow <= 1'b1;
            if (wd_hit)  timeout  <= 1'b1;
            if (!active || empty || bus.ret_valid) wd_q <= '0;
            else                                   wd_q <= wd_q + 1'b1;
        end
    end

    assign bus.exp_ready = !full && (state_q == RUN);
    assign done          = (state_q == DONE);
    assign halt          = (state_q == DONE) || (state_q == ERR);
endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker: a per-cycle vector table plus hand-written
// sequences for stop-on-fail, overflow, watchdog, drain/done and mid-run reset.
module tb_retire_checker;
    import retire_checker_pkg::*;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stop_on_fail = 1'b0;
    logic             end_test = 1'b0;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;
    logic             mismatch, overflow, timeout, done, halt;
    logic [31:0]      fail_instr;
    logic [XLEN-1:0]  fail_data;

    retire_checker_if #(.XLEN(XLEN)) bus ();

    retire_checker #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stop_on_fail (stop_on_fail),
        .end_test     (end_test),
        .bus          (bus),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .mismatch     (mismatch),
        .fail_instr   (fail_instr),
        .fail_data    (fail_data),
        .overflow     (overflow),
        .timeout      (timeout),
        .done         (done),
        .halt         (halt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        ev;
        logic [31:0] ei;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        rv;
        logic [31:0] ri;
        logic        rwe;
        logic [4:0]  rrd;
        logic [31:0] rdat;
        logic [15:0] xp;
        logic [15:0] xf;
        logic        xm;
        logic [31:0] xfi;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, OP_IMM};
    endfunction

    function automatic vec_t mk(input logic ev, input logic [31:0] ei, input logic ewe,
                                input logic [4:0] erd, input logic [31:0] ed,
                                input logic rv, input logic [31:0] ri, input logic rwe,
                                input logic [4:0] rrd, input logic [31:0] rdat,
                                input logic [15:0] xp, input logic [15:0] xf,
                                input logic xm, input logic [31:0] xfi);
        vec_t v;
        v.ev = ev;  v.ei = ei;  v.ewe = ewe; v.erd = erd; v.ed = ed;
        v.rv = rv;  v.ri = ri;  v.rwe = rwe; v.rrd = rrd; v.rdat = rdat;
        v.xp = xp;  v.xf = xf;  v.xm = xm;   v.xfi = xfi;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.exp_valid = 1'b0; bus.exp_instr = '0; bus.exp_we = 1'b0;
        bus.exp_rd = '0; bus.exp_data = '0;
        bus.ret_valid = 1'b0; bus.ret_instr = '0; bus.ret_we = 1'b0;
        bus.ret_rd = '0; bus.ret_data = '0;
        end_test = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] i, input logic we, input logic [4:0] rd,
                            input logic [31:0] d);
        bus.exp_valid = 1'b1; bus.exp_instr = i; bus.exp_we = we;
        bus.exp_rd = rd; bus.exp_data = d;
    endtask

    task automatic set_ret(input logic [31:0] i, input logic we, input logic [4:0] rd,
                           input logic [31:0] d);
        bus.ret_valid = 1'b1; bus.ret_instr = i; bus.ret_we = we;
        bus.ret_rd = rd; bus.ret_data = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pass_cnt"},   64'(pass_cnt),   64'd0);
        check({tag, " fail_cnt"},   64'(fail_cnt),   64'd0);
        check({tag, " mismatch"},   64'(mismatch),   64'd0);
        check({tag, " fail_instr"}, 64'(fail_instr), 64'd0);
        check({tag, " fail_data"},  64'(fail_data),  64'd0);
        check({tag, " overflow"},   64'(overflow),   64'd0);
        check({tag, " timeout"},    64'(timeout),    64'd0);
        check({tag, " done"},       64'(done),       64'd0);
        check({tag, " halt"},       64'(halt),       64'd0);
    endtask

    initial begin
        logic [31:0] i_addi, i_a;
        i_addi = addi(5'd1, 12'd5);
        i_a    = addi(5'd1, 12'd10);

        // ev ei ewe erd ed | rv ri rwe rrd rdat | pass fail mm fail_instr
        tbl.push_back(mk(1, i_addi, 1, 1, 5,           0, 0, 0, 0, 0,                        0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, i_addi, 1, 1, 5,                   1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,                0, 0, 0, 0, 0,                        1, 0, 0, 0));
        tbl.push_back(mk(1, addi(2, 7), 1, 2, 7,       0, 0, 0, 0, 0,                        1, 0, 0, 0));
        tbl.push_back(mk(1, 32'h00112023, 0, 0, 0,     1, addi(2, 7), 1, 2, 7,               2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 32'h00112023, 0, 5, 123,           3, 0, 0, 0));
        tbl.push_back(mk(1, addi(0, 0), 1, 0, 0,       0, 0, 0, 0, 0,                        3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, addi(0, 0), 1, 0, 32'hDEAD,        4, 0, 0, 0));
        tbl.push_back(mk(1, i_addi, 1, 1, 5,           0, 0, 0, 0, 0,                        4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, i_addi, 1, 2, 5,                   4, 1, 1, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                0, 0, 0, 0, 0,                        4, 1, 0, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, 32'h11111111, 1, 3, 32'h22,        4, 2, 1, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                0, 0, 0, 0, 0,                        4, 2, 0, i_addi));
        tbl.push_back(mk(1, i_a, 1, 1, 10,             1, addi(1, 11), 1, 1, 10,             4, 3, 1, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, i_a, 1, 1, 10,                     5, 3, 0, i_addi));
        tbl.push_back(mk(1, i_a, 1, 1, 10,             0, 0, 0, 0, 0,                        5, 3, 0, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, i_a, 0, 1, 10,                     5, 4, 1, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                0, 0, 0, 0, 0,                        5, 4, 0, i_addi));
        tbl.push_back(mk(1, i_a, 1, 1, 10,             0, 0, 0, 0, 0,                        5, 4, 0, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, i_a, 1, 1, 11,                     5, 5, 1, i_addi));
        tbl.push_back(mk(1, i_a, 1, 1, 10,             0, 0, 0, 0, 0,                        5, 5, 0, i_addi));
        tbl.push_back(mk(0, 0, 0, 0, 0,                1, addi(3, 10), 1, 1, 10,             5, 6, 1, i_addi));

        // Reset state
        do_reset();
        check_all_zero("reset");
        check("reset exp_ready", 64'(bus.exp_ready), 64'd1);

        // Vector table, log-and-continue mode
        stop_on_fail = 1'b0;
        foreach (tbl[k]) begin
            clear_inputs();
            if (tbl[k].ev) set_push(tbl[k].ei, tbl[k].ewe, tbl[k].erd, tbl[k].ed);
            if (tbl[k].rv) set_ret(tbl[k].ri, tbl[k].rwe, tbl[k].rrd, tbl[k].rdat);
            tick();
            check($sformatf("row%0d pass_cnt", k),   64'(pass_cnt),   64'(tbl[k].xp));
            check($sformatf("row%0d fail_cnt", k),   64'(fail_cnt),   64'(tbl[k].xf));
            check($sformatf("row%0d mismatch", k),   64'(mismatch),   64'(tbl[k].xm));
            check($sformatf("row%0d fail_instr", k), 64'(fail_instr), 64'(tbl[k].xfi));
            check($sformatf("row%0d halt", k),       64'(halt),       64'd0);
        end
        clear_inputs();
        check("table fail_data", 64'(fail_data), 64'd5);

        // Stop on fail: second of three retirements carries wrong data
        do_reset();
        stop_on_fail = 1'b1;
        set_push(addi(1, 1), 1, 1, 1); tick();
        set_push(addi(2, 7), 1, 2, 7); tick();
        set_push(addi(3, 3), 1, 3, 3); tick();
        clear_inputs();
        set_ret(addi(1, 1), 1, 1, 1); tick();
        check("sof first pass_cnt", 64'(pass_cnt), 64'd1);
        check("sof first mismatch", 64'(mismatch), 64'd0);
        set_ret(addi(2, 7), 1, 2, 6); tick();
        check("sof mismatch",   64'(mismatch),   64'd1);
        check("sof fail_cnt",   64'(fail_cnt),   64'd1);
        check("sof fail_data",  64'(fail_data),  64'd6);
        check("sof fail_instr", 64'(fail_instr), 64'(addi(2, 7)));
        check("sof halt",       64'(halt),       64'd1);
        check("sof done",       64'(done),       64'd0);
        set_ret(addi(3, 3), 1, 3, 3); tick();
        check("sof ignored pass_cnt", 64'(pass_cnt), 64'd1);
        check("sof pulse ends",       64'(mismatch), 64'd0);
        check("sof still halted",     64'(halt),     64'd1);
        clear_inputs();
        rst = 1'b0;
        set_ret(addi(3, 3), 1, 3, 3);
        tick();
        check_all_zero("midrst1");
        clear_inputs();
        rst = 1'b1;

        // Fill to DEPTH, then push+pop while full, then push while full
        do_reset();
        stop_on_fail = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            set_push(32'h1000_0000 + i, 0, 0, 0);
            tick();
        end
        clear_inputs();
        check("full exp_ready", 64'(bus.exp_ready), 64'd0);
        set_push(32'h1000_0008, 0, 0, 0);
        set_ret(32'h1000_0000, 0, 0, 0);
        tick();
        clear_inputs();
        check("full pushpop overflow", 64'(overflow), 64'd0);
        check("full pushpop pass_cnt", 64'(pass_cnt), 64'd1);
        check("full pushpop halt",     64'(halt),     64'd0);
        check("full pushpop still full", 64'(bus.exp_ready), 64'd0);
        set_push(32'h1000_0009, 0, 0, 0);
        tick();
        clear_inputs();
        check("overflow flag", 64'(overflow), 64'd1);
        check("overflow halt", 64'(halt),     64'd1);
        tick();
        check("overflow sticky", 64'(overflow), 64'd1);

        // Watchdog: one entry, no retirement
        do_reset();
        set_push(addi(1, 1), 1, 1, 1); tick();
        clear_inputs();
        repeat (TIMEOUT - 1) tick();
        check("wd before timeout", 64'(timeout), 64'd0);
        check("wd before halt",    64'(halt),    64'd0);
        tick();
        check("wd timeout", 64'(timeout), 64'd1);
        check("wd halt",    64'(halt),    64'd1);

        // Drain then done; pushes during drain are ignored
        do_reset();
        set_push(addi(1, 1), 1, 1, 1); tick();
        set_push(addi(2, 2), 1, 2, 2); tick();
        clear_inputs();
        end_test = 1'b1; tick();
        clear_inputs();
        check("drain exp_ready", 64'(bus.exp_ready), 64'd0);
        check("drain done",      64'(done),          64'd0);
        set_ret(addi(1, 1), 1, 1, 1); tick();
        clear_inputs();
        set_ret(addi(2, 2), 1, 2, 2);
        set_push(addi(4, 4), 1, 4, 4);
        tick();
        clear_inputs();
        check("drain last done",     64'(done),     64'd0);
        check("drain last pass_cnt", 64'(pass_cnt), 64'd2);
        tick();
        check("done flag",     64'(done),     64'd1);
        check("done halt",     64'(halt),     64'd1);
        check("done pass_cnt", 64'(pass_cnt), 64'd2);
        check("done fail_cnt", 64'(fail_cnt), 64'd0);
        rst = 1'b0;
        tick();
        check_all_zero("midrst2");
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
